wb_merge: RTL and testbench
===========================

# wb_merge

Write-back merge stage between the MEM/WB pipeline register and the register file write port. Combines the in-order pipeline write-back stream with results from long-latency units (multiplier/divider) through a small pending-write buffer. Drives the register file's single write port from a register. Reports pending buffered writes to decode so it can stall on hazards.

## Interface
- DEPTH, 4: pending-buffer entries; power of two, ≥2
- STARVE_MAX, 8: consecutive no-drain cycles before a stall request (only with WB_MERGE_STARVE_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- wb_we  in  1  pipeline write-back valid
- wb_waddr  in  `RegAddrBus  pipeline destination register
- wb_wdata  in  `RegDataBus  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  buffer can accept
- lu_waddr  in  `RegAddrBus  long-latency destination
- lu_wdata  in  `RegDataBus  long-latency result
- we  out  1  register file write enable
- waddr  out  `RegAddrBus  register file write address
- wdata  out  `RegDataBus  register file write data
- raddr_1, raddr_2  in  `RegAddrBus  decode read addresses
- pend_hit_1, pend_hit_2  out  1  raddr has a live buffered write
- stall_req  out  1  request pipeline bubble to drain buffer

## Operation
- Buffer: circular FIFO, DEPTH entries of {live, waddr, wdata}; rd/wr pointers plus count (0..DEPTH).
- lu_ready = (count < DEPTH); depends only on state, never on lu_valid. Push on lu_valid && lu_ready.
- Push with lu_waddr == `RegAddr_0: handshake completes, nothing stored.
- Selection each cycle: if wb_we && wb_waddr != `RegAddr_0 -> pipeline write wins; else if count > 0 -> pop head.
- Popping a head with live=1 produces a write; with live=0 pops silently (we=0 that cycle, slot consumed).
- wb_we with wb_waddr == `RegAddr_0: no write; buffer may pop that cycle.
- Kill rule: pipeline write to X clears live on every existing entry with waddr X (newer value must not be overwritten). An entry pushed in the same cycle is not killed.
- pend_hit_n = OR over occupied entries of (live && waddr == raddr_n); 0 when raddr_n == `RegAddr_0. Combinational.
- Push and pop in the same cycle allowed when count < DEPTH; count unchanged.

## Timing
- Reset (rst low, asynchronous): we=0, waddr=0, wdata=`ZeroWord, count=0, pointers=0, all live=0, starve counter=0, stall_req=0; lu_ready=0 while rst low, 1 the cycle after release.
- Latency: selected write appears on we/waddr/wdata one clock after input cycle; regfile commits on the following edge.
- lu result: earliest write at cycle push+2 (stored at edge 1, popped/registered at edge 2).
- Full buffer: lu_ready=0 even if a pop occurs that cycle; reasserts cycle after pop.
- Mid-operation reset discards all buffered entries; no write issued.

## Configuration
- WB_MERGE_STARVE_EN defined: counter increments each cycle with count>0 and no pop, clears on any pop or count==0; at STARVE_MAX sets stall_req (registered), held until next pop. Upstream guarantees wb_we=0 within 2 cycles of stall_req.
- Undefined: no counter; stall_req tied 0; buffer drains only in pipeline bubbles.

## Structure
- define.vh: reuse `RegAddrBus, `RegDataBus, `RegAddr_0, `ZeroWord; add `WbDepth (4) and `WbStarveMax (8) defaults.
- Sub-module wb_pend_fifo: storage, pointers, count, kill CAM, hit lookup; wb_merge holds selection, output register, starve logic.

## Test plan
- Pipeline only: wb_we=1, waddr=5, wdata=0x1234 -> next cycle we=1, waddr=5, wdata=0x1234.
- lu push waddr=7, 0xAA with wb_we=0 -> we=1, waddr=7, wdata=0xAA two cycles later; pend_hit for raddr=7 high one cycle.
- Fill 4 entries while wb_we=1 continuously -> lu_ready=0 at count 4; with STARVE_EN stall_req=1 after 8 cycles; drop wb_we -> entries drain in order, stall_req clears on first pop.
- Buffered write to r3=0x11, then pipeline write r3=0x22 -> pend_hit r3 drops; final r3 = 0x22, killed pop gives we=0.
- lu push to r0 and wb write to r0 -> no we asserted, count stays 0.
- rst low with 3 buffered entries -> outputs zero immediately; after release no writes, lu_ready=1.

Source files
------------

// File: rtl/wb_merge_pkg.sv
// Shared types and defaults for the write-back merge stage.
// Register-file widths, the zero register, and the pending-buffer entry layout.
package wb_merge_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 32;
  localparam int WB_DEPTH      = 4;
  localparam int WB_STARVE_MAX = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ADDR_0 = '0;
  localparam reg_data_t ZERO_WORD  = '0;

  typedef struct packed {
    logic      live;
    reg_addr_t waddr;
    reg_data_t wdata;
  } pend_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-write buffer: circular FIFO of {live, waddr, wdata} with a kill CAM
// that retires stale entries and a read-address lookup for hazard detection.
module wb_pend_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  reg_addr_t   push_waddr_i,
  input  reg_data_t   push_wdata_i,
  output logic        ready_o,
  input  logic        pop_i,
  input  logic        kill_i,
  input  reg_addr_t   kill_waddr_i,
  output logic        nonempty_o,
  output pend_entry_t head_o,
  input  reg_addr_t   raddr_1_i,
  input  reg_addr_t   raddr_2_i,
  output logic        hit_1_o,
  output logic        hit_2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic             alive_q;
  reg_addr_t        addr_q [DEPTH];
  reg_data_t        data_q [DEPTH];
  logic             do_push, do_store, do_pop;

  // alive_q keeps ready low for the whole reset and the edge that releases it.
  assign ready_o    = alive_q && (count_q < DEPTH_C);
  assign do_push    = push_i && ready_o;
  assign do_store   = do_push && (push_waddr_i != REG_ADDR_0);
  assign do_pop     = pop_i && (count_q != '0);
  assign nonempty_o = (count_q != '0);
  assign head_o     = '{live: live_q[rd_ptr_q], waddr: addr_q[rd_ptr_q], wdata: data_q[rd_ptr_q]};

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    live_d   = live_q;
    // Popping clears live, so live alone marks an occupied, still-valid slot.
    if (do_pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == kill_waddr_i) live_d[i] = 1'b0;
      end
    end
    // Applied after the kill so an entry written this cycle survives it.
    if (do_store) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    case ({do_store, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    hit_1_o = 1'b0;
    hit_2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == raddr_1_i)) hit_1_o = 1'b1;
      if (live_q[i] && (addr_q[i] == raddr_2_i)) hit_2_o = 1'b1;
    end
    if (raddr_1_i == REG_ADDR_0) hit_1_o = 1'b0;
    if (raddr_2_i == REG_ADDR_0) hit_2_o = 1'b0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      alive_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      alive_q  <= 1'b1;
    end
  end

  // NOTE: payload storage has no reset; cleared live bits make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_store) begin
      addr_q[wr_ptr_q] <= push_waddr_i;
      data_q[wr_ptr_q] <= push_wdata_i;
    end
  end

endmodule

// File: rtl/wb_merge.sv
// Write-back merge: pipeline writes win the register-file port, buffered
// long-latency results drain otherwise. Define WB_MERGE_STARVE_EN for stall_req.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_we,
  input  reg_addr_t wb_waddr,
  input  reg_data_t wb_wdata,
  input  logic      lu_valid,
  output logic      lu_ready,
  input  reg_addr_t lu_waddr,
  input  reg_data_t lu_wdata,
  output logic      we,
  output reg_addr_t waddr,
  output reg_data_t wdata,
  input  reg_addr_t raddr_1,
  input  reg_addr_t raddr_2,
  output logic      pend_hit_1,
  output logic      pend_hit_2,
  output logic      stall_req
);

  logic        sel_wb, pop, nonempty;
  pend_entry_t head;
  logic        we_q, we_d;
  reg_addr_t   waddr_q, waddr_d;
  reg_data_t   wdata_q, wdata_d;

  assign sel_wb = wb_we && (wb_waddr != REG_ADDR_0);
  assign pop    = !sel_wb && nonempty;

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (lu_valid),
    .push_waddr_i (lu_waddr),
    .push_wdata_i (lu_wdata),
    .ready_o      (lu_ready),
    .pop_i        (pop),
    .kill_i       (sel_wb),
    .kill_waddr_i (wb_waddr),
    .nonempty_o   (nonempty),
    .head_o       (head),
    .raddr_1_i    (raddr_1),
    .raddr_2_i    (raddr_2),
    .hit_1_o      (pend_hit_1),
    .hit_2_o      (pend_hit_2)
  );

  // Address/data hold their last value when no write issues.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (sel_wb) begin
      we_d    = 1'b1;
      waddr_d = wb_waddr;
      wdata_d = wb_wdata;
    end else if (pop && head.live) begin
      we_d    = 1'b1;
      waddr_d = head.waddr;
      wdata_d = head.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= REG_ADDR_0;
      wdata_q <= ZERO_WORD;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

`ifdef WB_MERGE_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop || !nonempty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
    if (pop) begin
      stall_d = 1'b0;
    end else if (starve_d == STARVE_LIM) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_req = stall_q;
`else
  // STARVE_MAX only matters when the starvation counter is built in.
  assign stall_req = 1'b0 && (STARVE_MAX > 0);
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the merge rules.
module tb_wb_merge;
  import wb_merge_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic      clk, rst;
  logic      wb_we, lu_valid, lu_ready, we;
  reg_addr_t wb_waddr, lu_waddr, waddr, raddr_1, raddr_2;
  reg_data_t wb_wdata, lu_wdata, wdata;
  logic      pend_hit_1, pend_hit_2, stall_req;

  wb_merge #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr_1    (raddr_1),
    .raddr_2    (raddr_2),
    .pend_hit_1 (pend_hit_1),
    .pend_hit_2 (pend_hit_2),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        live;
    reg_addr_t a;
    reg_data_t d;
  } ent_t;

  ent_t      q[$];
  bit        m_we, m_alive, m_stall;
  reg_addr_t m_waddr;
  reg_data_t m_wdata;
  int        m_starve;
  reg_data_t dut_rf [32];
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 0; m_waddr = '0; m_wdata = '0;
    m_alive = 0; m_starve = 0; m_stall = 0;
  endtask

  task automatic model_update();
    int   n;
    bit   sel, pop, rdy;
    ent_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    n    = q.size();
    rdy  = m_alive && (n < DEPTH);
    sel  = wb_we && (wb_waddr != 0);
    pop  = !sel && (n > 0);
    m_we = 0;
    if (sel) begin
      m_we = 1; m_waddr = wb_waddr; m_wdata = wb_wdata;
      foreach (q[i]) if (q[i].a == wb_waddr) q[i].live = 0;
    end else if (pop) begin
      e = q.pop_front();
      if (e.live) begin
        m_we = 1; m_waddr = e.a; m_wdata = e.d;
      end
    end
    if (lu_valid && rdy && (lu_waddr != 0)) q.push_back('{1'b1, lu_waddr, lu_wdata});
`ifdef WB_MERGE_STARVE_EN
    if (pop) begin
      m_starve = 0; m_stall = 0;
    end else if (n == 0) begin
      m_starve = 0;
    end else begin
      if (m_starve < STARVE_MAX) m_starve++;
      if (m_starve >= STARVE_MAX) m_stall = 1;
    end
`endif
    m_alive = 1;
  endtask

  function automatic bit model_hit(input reg_addr_t ra);
    if (ra == 0) return 0;
    foreach (q[i]) if (q[i].live && q[i].a == ra) return 1;
    return 0;
  endfunction

  task automatic compare_all();
    check("we", we, m_we);
    if (m_we) begin
      check("waddr", waddr, m_waddr);
      check("wdata", wdata, m_wdata);
    end
    check("lu_ready", lu_ready, m_alive && (q.size() < DEPTH));
    check("pend_hit_1", pend_hit_1, model_hit(raddr_1));
    check("pend_hit_2", pend_hit_2, model_hit(raddr_2));
    check("stall_req", stall_req, m_stall);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (we) dut_rf[waddr] = wdata;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_waddr = '0; wb_wdata = '0;
    lu_valid = 0; lu_waddr = '0; lu_wdata = '0;
  endtask

  initial begin
    foreach (dut_rf[i]) dut_rf[i] = '0;
    idle_inputs();
    raddr_1 = '0; raddr_2 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("reset_we", we, 1'b0);
    check("reset_lu_ready", lu_ready, 1'b0);
    step(); step();
    #2 rst = 1'b1;
    step();
    check("ready_after_release", lu_ready, 1'b1);

    // Pipeline-only write
    wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
    step();
    check("pipe_we", we, 1'b1);
    check("pipe_waddr", waddr, 5'd5);
    check("pipe_wdata", wdata, 32'h1234);

    // Long-latency push lands two cycles later
    wb_we = 0; lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'hAA; raddr_1 = 5'd7;
    step();
    lu_valid = 0;
    #1;
    check("lu_hit_stored", pend_hit_1, 1'b1);
    check("lu_we_edge1", we, 1'b0);
    step();
    check("lu_we_edge2", we, 1'b1);
    check("lu_waddr", waddr, 5'd7);
    check("lu_wdata", wdata, 32'hAA);
    check("lu_hit_cleared", pend_hit_1, 1'b0);

    // Fill while the pipeline owns the port, then drain in order
    for (int i = 0; i < 4; i++) begin
      wb_we = 1; wb_waddr = reg_addr_t'(20 + i); wb_wdata = 32'h100 + i;
      lu_valid = 1; lu_waddr = reg_addr_t'(10 + i); lu_wdata = 32'hB0 + i;
      step();
    end
    lu_valid = 0;
    #1;
    check("full_not_ready", lu_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wb_waddr = reg_addr_t'(24 + i);
      step();
    end
`ifdef WB_MERGE_STARVE_EN
    check("starve_stall", stall_req, 1'b1);
`endif
    wb_we = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_addr", waddr, 10 + i);
      check("drain_data", wdata, 32'hB0 + i);
      if (i == 0) begin
        check("ready_after_pop", lu_ready, 1'b1);
        check("stall_cleared", stall_req, 1'b0);
      end
    end

    // Kill: newer pipeline value to r3 retires the buffered one
    wb_we = 1; wb_waddr = 5'd20; wb_wdata = 32'h5;
    lu_valid = 1; lu_waddr = 5'd3; lu_wdata = 32'h11;
    step();
    lu_valid = 0; wb_waddr = 5'd3; wb_wdata = 32'h22; raddr_1 = 5'd3;
    #1;
    check("kill_hit_before", pend_hit_1, 1'b1);
    step();
    check("kill_pipe_addr", waddr, 5'd3);
    check("kill_pipe_data", wdata, 32'h22);
    check("kill_hit_after", pend_hit_1, 1'b0);
    wb_we = 0;
    step();
    check("killed_pop_we", we, 1'b0);
    step(); step();
    check("rf_r3_final", dut_rf[3], 32'h22);

    // r0 on both sources: nothing written, nothing stored
    wb_we = 1; wb_waddr = '0; wb_wdata = 32'hDEAD;
    lu_valid = 1; lu_waddr = '0; lu_wdata = 32'hBEEF;
    step();
    check("r0_we", we, 1'b0);
    idle_inputs();
    step();
    check("r0_no_pop", we, 1'b0);

    // Reset with buffered entries discards them
    for (int i = 0; i < 3; i++) begin
      wb_we = 1; wb_waddr = 5'd21; wb_wdata = 32'h7;
      lu_valid = 1; lu_waddr = reg_addr_t'(4 + i); lu_wdata = 32'hC0 + i;
      step();
    end
    idle_inputs();
    raddr_1 = 5'd5;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_waddr", waddr, 5'd0);
    check("mid_rst_wdata", wdata, 32'h0);
    check("mid_rst_ready", lu_ready, 1'b0);
    check("mid_rst_hit", pend_hit_1, 1'b0);
    check("mid_rst_stall", stall_req, 1'b0);
    step();
    #2 rst = 1'b1;
    step();
    check("post_rst_ready", lu_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_write", we, 1'b0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wb_we    = ($urandom_range(0, 99) < 45);
      wb_waddr = reg_addr_t'($urandom_range(0, 7));
      wb_wdata = $urandom;
      lu_valid = ($urandom_range(0, 99) < 50);
      lu_waddr = reg_addr_t'($urandom_range(0, 7));
      lu_wdata = $urandom;
      raddr_1  = reg_addr_t'($urandom_range(0, 7));
      raddr_2  = reg_addr_t'($urandom_range(0, 7));
      if (i == 1500) begin
        #2 rst = 1'b0;
        model_reset();
      end
      if (i == 1502) rst = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
